// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_pkg
// Brief  : Shared constants and types for the framebuffer command writer.
//          Framebuffer geometry, command opcodes and the writer FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package fb_pkg;

  localparam int unsigned FB_W = 16;  // pixels per row, x field 4 bits
  localparam int unsigned FB_H = 12;  // rows, y field 4 bits

  // 4-bit views of the row geometry for compares against the y field
  localparam logic [3:0] Y_LIMIT  = 4'(FB_H);
  localparam logic [3:0] ROW_LAST = 4'(FB_H - 1);

  // Opcode lives in cmd_data[7:6] of the first command byte
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_FILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARG   = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_cmd_writer_if.sv
`default_nettype none
// ============================================================================
// Module : fb_cmd_writer_if
// Brief  : Byte command stream with valid/ready handshake.
//          A byte transfers on the clk edge where cmd_valid && cmd_ready.
// Ports  : cmd_valid (source->sink), cmd_data[7:0] (source->sink),
//          cmd_ready (sink->source)
// Rev    : 1.0  initial release
// ============================================================================
interface fb_cmd_writer_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/fb_mem.sv
`default_nettype none
// ============================================================================
// Module : fb_mem
// Brief  : FB_H x FB_W 1-bit framebuffer storage.
//          Single-bit write, whole-row write, synchronous clear on rst and a
//          registered read port. A read colliding with a write on the same
//          edge returns the pre-write value.
// Ports  : clk, rst         clock / sync active-high clear
//          bit_we/x/y/val   single pixel write
//          row_we/idx/val   whole-row write (all bits = row_val)
//          rd_x, rd_y       read address
//          rd_pix           pixel data, one cycle after the address
// Rev    : 1.0  initial release
// ============================================================================
module fb_mem
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_we,
  input  logic [3:0] bit_x,
  input  logic [3:0] bit_y,
  input  logic       bit_val,
  input  logic       row_we,
  input  logic [3:0] row_idx,
  input  logic       row_val,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_pix
);

  logic [FB_W-1:0] rows [FB_H];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(FB_H); r++) begin
        rows[r] <= '0;
      end
      rd_pix <= 1'b0;
    end else begin
      if (row_we) begin
        rows[row_idx] <= {FB_W{row_val}};
      end
      if (bit_we) begin
        rows[bit_y][bit_x] <= bit_val;
      end
      // Rows beyond the framebuffer read as blank
      rd_pix <= (rd_y < Y_LIMIT) ? rows[rd_y][rd_x] : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module : fb_cmd_writer
// Brief  : Fills the 16x12 1-bit framebuffer from a byte command stream and
//          serves the VGA scan-out through a registered read port.
//          Commands: NOP, SET/CLR pixel (opcode + x/y argument byte),
//          FILL whole buffer (one row per cycle).
// Ports  : clk, rst     clock / sync active-high reset
//          cmd          byte command stream (slave side)
//          rd_x, rd_y   scan-out read address
//          rd_pix       pixel at (rd_x,rd_y), latency 1
//          busy         high while a fill sweep runs
//          err          one-cycle pulse: y out of range, write dropped
// Rev    : 1.0  initial release
// ============================================================================
module fb_cmd_writer
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fb_cmd_writer_if.slave        cmd,
  input  logic [3:0]            rd_x,
  input  logic [3:0]            rd_y,
  output logic                  rd_pix,
  output logic                  busy,
  output logic                  err
);

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic       fill_q;
  logic [3:0] row_q;
  logic       err_q;

  logic       accept;
  logic       bit_we, row_we, err_set;
  logic       mem_pix;

  wire [1:0]  cmd_op = cmd.cmd_data[7:6];
  wire [3:0]  arg_x  = cmd.cmd_data[7:4];
  wire [3:0]  arg_y  = cmd.cmd_data[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    bit_we        = 1'b0;
    row_we        = 1'b0;
    err_set       = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        accept        = cmd.cmd_valid;
        if (cmd.cmd_valid) begin
          unique case (cmd_op)
            OP_SET, OP_CLR: state_nxt = ARG;
            OP_FILL:        state_nxt = SWEEP;
            OP_NOP:         state_nxt = IDLE;
            default:        state_nxt = IDLE;
          endcase
        end
      end
      ARG: begin
        cmd.cmd_ready = 1'b1;
        accept        = cmd.cmd_valid;
        if (cmd.cmd_valid) begin
          if (arg_y < Y_LIMIT) begin
            bit_we = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      SWEEP: begin
        busy   = 1'b1;
        row_we = 1'b1;
        if (row_q == ROW_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are held inactive for the whole reset, not only after its edge
    if (rst) begin
      cmd.cmd_ready = 1'b0;
      busy          = 1'b0;
      accept        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NOP;
      fill_q <= 1'b0;
      row_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_set;
      if (state == IDLE && accept) begin
        op_q   <= cmd_op;
        fill_q <= cmd.cmd_data[0];
        row_q  <= '0;
      end else if (row_we) begin
        // Wrap on the last row so the counter never leaves 0..FB_H-1
        row_q <= (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
      end
    end
  end

  fb_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .bit_we  (bit_we),
    .bit_x   (arg_x),
    .bit_y   (arg_y),
    .bit_val (op_q == OP_SET),
    .row_we  (row_we),
    .row_idx (row_q),
    .row_val (fill_q),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_pix  (mem_pix)
  );

  assign rd_pix = mem_pix & ~rst;
  assign err    = err_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_fb_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_fb_cmd_writer
// Brief  : Self-checking bench for fb_cmd_writer. A bench-side pixel model
//          supplies expected read data, queued when a read address is driven
//          and compared when rd_pix appears one cycle later.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fb_cmd_writer;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rd_x = '0;
  logic [3:0] rd_y = '0;
  logic       rd_pix, busy, err;

  fb_cmd_writer_if bus ();

  fb_cmd_writer dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (bus.slave),
    .rd_x   (rd_x),
    .rd_y   (rd_y),
    .rd_pix (rd_pix),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  logic model [FB_H][FB_W];
  logic exp_q [$];

  task automatic model_fill(input logic v);
    for (int y = 0; y < int'(FB_H); y++)
      for (int x = 0; x < int'(FB_W); x++)
        model[y][x] = v;
  endtask

  // Present a byte and hold it until the DUT takes it; returns at the
  // falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (bus.cmd_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      total++;
      $display("FAIL send_timeout byte=%02h ready=%b required 1", b, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'($urandom);
  endtask

  task automatic test_readback_all(input string tag);
    logic e;
    for (int i = 0; i < int'(FB_H * FB_W); i++) begin
      rd_x = 4'(i % int'(FB_W));
      rd_y = 4'(i / int'(FB_W));
      exp_q.push_back(model[i / int'(FB_W)][i % int'(FB_W)]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (rd_pix !== e)
        $display("FAIL %s pix(%0d,%0d) got=%b exp=%b", tag, i % int'(FB_W), i / int'(FB_W), rd_pix, e);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", bus.cmd_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
    total++; if (rd_pix !== 1'b0) $display("FAIL rst_pix got=%b exp=0", rd_pix); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", bus.cmd_ready); else passed++;
    model_fill(1'b0);
    @(negedge clk);
    test_readback_all("reset_scan");
  endtask

  task automatic test_set();
    int w;
    logic [3:0] pts [3][2];
    logic e;
    send_byte(8'h40, w);
    send_byte(8'h35, w);
    model[5][3] = 1'b1;
    pts[0][0] = 4'd3; pts[0][1] = 4'd5;
    pts[1][0] = 4'd2; pts[1][1] = 4'd5;
    pts[2][0] = 4'd3; pts[2][1] = 4'd4;
    for (int i = 0; i < 3; i++) begin
      rd_x = pts[i][0];
      rd_y = pts[i][1];
      exp_q.push_back(model[pts[i][1]][pts[i][0]]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (rd_pix !== e) $display("FAIL set_pix(%0d,%0d) got=%b exp=%b", pts[i][0], pts[i][1], rd_pix, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [7:0] seq [4];
    seq[0] = 8'h40; seq[1] = 8'h00; seq[2] = 8'h40; seq[3] = 8'hFB;
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], w);
      total++;
      if (w !== 0) $display("FAIL b2b_wait byte%0d got=%0d exp=0", i, w); else passed++;
    end
    model[0][0]  = 1'b1;
    model[11][15] = 1'b1;
  endtask

  task automatic test_fill();
    int w, cnt, bad_ready;
    logic e;
    send_byte(8'hC1, w);
    cnt = 0;
    bad_ready = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (bus.cmd_ready !== 1'b0) bad_ready++;
      cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== 12) $display("FAIL fill_busy_cycles got=%0d exp=12", cnt); else passed++;
    total++; if (bad_ready !== 0) $display("FAIL fill_ready_during_busy got=%0d exp=0", bad_ready); else passed++;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL fill_ready_after got=%b exp=1", bus.cmd_ready); else passed++;
    model_fill(1'b1);
    test_readback_all("fill1_scan");
    // Row 12 does not exist and must read blank
    rd_x = 4'd0;
    rd_y = 4'd12;
    exp_q.push_back(1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (rd_pix !== e) $display("FAIL oob_row_read got=%b exp=%b", rd_pix, e); else passed++;
    send_byte(8'h80, w);
    send_byte(8'hB0, w);
    model[0][11] = 1'b0;
    test_readback_all("clr_scan");
  endtask

  task automatic test_err();
    int w;
    send_byte(8'h40, w);
    total++; if (err !== 1'b0) $display("FAIL err_early got=%b exp=0", err); else passed++;
    send_byte(8'h0C, w);
    total++; if (err !== 1'b1) $display("FAIL err_pulse got=%b exp=1", err); else passed++;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL err_ready got=%b exp=1", bus.cmd_ready); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL err_width got=%b exp=0", err); else passed++;
    test_readback_all("err_scan");
  endtask

  task automatic test_hold_during_sweep();
    int w;
    send_byte(8'hC0, w);
    send_byte(8'h40, w);
    total++; if (w !== 12) $display("FAIL hold_wait got=%0d exp=12", w); else passed++;
    send_byte(8'h11, w);
    total++; if (w !== 0) $display("FAIL hold_arg_wait got=%0d exp=0", w); else passed++;
    model_fill(1'b0);
    model[1][1] = 1'b1;
    test_readback_all("hold_scan");
  endtask

  task automatic test_collision();
    int w;
    logic e;
    send_byte(8'h40, w);
    rd_x = 4'd7;
    rd_y = 4'd7;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h77;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL coll_ready got=%b exp=1", bus.cmd_ready); else passed++;
    exp_q.push_back(model[7][7]);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    e = exp_q.pop_front();
    total++; if (rd_pix !== e) $display("FAIL coll_old_value got=%b exp=%b", rd_pix, e); else passed++;
    model[7][7] = 1'b1;
    exp_q.push_back(model[7][7]);
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (rd_pix !== e) $display("FAIL coll_new_value got=%b exp=%b", rd_pix, e); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int w;
    send_byte(8'hC1, w);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL midfill_busy got=%b exp=1", busy); else passed++;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
    total++; if (bus.cmd_ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", bus.cmd_ready); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL midrst_idle_ready got=%b exp=1", bus.cmd_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_idle_busy got=%b exp=0", busy); else passed++;
    model_fill(1'b0);
    @(negedge clk);
    test_readback_all("midrst_scan");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    test_reset();
    test_set();
    test_back_to_back();
    test_fill();
    test_err();
    test_hold_during_sweep();
    test_collision();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
